// File: rtl/io_write_arbiter.sv
// Two-requester write arbiter for the memory-mapped output-port bus.
// Grants one request per cycle, decodes the three port slots and drives registered write strobes and acks.
module io_write_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        io_clk,
    input  logic        clr,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic [31:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] data1,
    output logic        ack1,
    output logic        err,
    output logic [31:0] io_addr,
    output logic [31:0] io_data,
    output logic        io_we
);

    localparam logic [5:0] PORT0_SEL = 6'b100011;
    localparam logic [5:0] PORT1_SEL = 6'b100100;
    localparam logic [5:0] PORT2_SEL = 6'b100101;

    // Only word-address bits [7:2] select a port; all other bits are ignored.
    function automatic logic addr_mapped(input logic [31:0] a);
        case (a[7:2])
            PORT0_SEL: return 1'b1;
            PORT1_SEL: return 1'b1;
            PORT2_SEL: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    logic        elig0_s, elig1_s;
    logic        grant0_s, grant1_s;
    logic        win_mapped_s;
    logic [31:0] win_addr_s, win_data_s;

    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err_q, err_d;
    logic        io_we_q, io_we_d;
    logic        ptr_q, ptr_d;
    logic [31:0] io_addr_q, io_addr_d;
    logic [31:0] io_data_q, io_data_d;

    // Arbitration, address decode and next-state of every registered output.
    always_comb begin
        elig0_s  = req0 & ~ack0_q;
        elig1_s  = req1 & ~ack1_q;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        // ptr_q names the last winner; on a round-robin tie the other requester wins.
        if (elig0_s && elig1_s) begin
            if (ROUND_ROBIN && (ptr_q == 1'b0)) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else if (elig0_s) begin
            grant0_s = 1'b1;
        end else if (elig1_s) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end

        if (grant1_s) begin
            win_addr_s = addr1;
            win_data_s = data1;
        end else begin
            win_addr_s = addr0;
            win_data_s = data0;
        end
        win_mapped_s = addr_mapped(win_addr_s);

        ack0_d  = grant0_s;
        ack1_d  = grant1_s;
        io_we_d = (grant0_s | grant1_s) & win_mapped_s;
        err_d   = (grant0_s | grant1_s) & ~win_mapped_s;

        if (io_we_d) begin
            io_addr_d = win_addr_s;
            io_data_d = win_data_s;
        end else begin
            io_addr_d = io_addr_q;
            io_data_d = io_data_q;
        end

        if (grant1_s) begin
            ptr_d = 1'b1;
        end else if (grant0_s) begin
            ptr_d = 1'b0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State registers; pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge io_clk or posedge clr) begin
        if (clr) begin
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err_q     <= 1'b0;
            io_we_q   <= 1'b0;
            ptr_q     <= 1'b1;
            io_addr_q <= 32'h0000_0000;
            io_data_q <= 32'h0000_0000;
        end else begin
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err_q     <= err_d;
            io_we_q   <= io_we_d;
            ptr_q     <= ptr_d;
            io_addr_q <= io_addr_d;
            io_data_q <= io_data_d;
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign err     = err_q;
    assign io_we   = io_we_q;
    assign io_addr = io_addr_q;
    assign io_data = io_data_q;

endmodule
